// File: rtl/wshb_arb_pkg.sv
// Shared definitions for the Wishbone SDRAM-port arbiter.
package wshb_arb_pkg;

  // Default configuration: two masters, grant may be rotated after 64 acks.
  localparam int DEF_NB_MASTERS = 2;
  localparam int DEF_MAX_ACKS   = 64;

  // IDLE: nobody owns the slave (gnt == 0). OWN: exactly one grant bit set.
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wshb_arbiter_if.sv
// Arbitration handshake bundle between the masters' side and the arbiter.
interface wshb_arbiter_if
  import wshb_arb_pkg::*;
#(
  parameter int NB_MASTERS = DEF_NB_MASTERS
);

  localparam int IDX_W = $clog2(NB_MASTERS);

  logic [NB_MASTERS-1:0] req;        // cyc of each master
  logic                  stb_gnt;    // stb of the granted master, after the mux
  logic                  ack_s;      // slave ack | err | rty
  logic [NB_MASTERS-1:0] gnt;        // one-hot grant, external mux select
  logic [IDX_W-1:0]      gnt_idx;    // binary index of the granted master
  logic                  gnt_valid;  // high exactly when gnt != 0
  logic                  preempt;    // one-cycle pulse on forced rotation

  // Requesting side: masters and slave response.
  modport master (
    output req, stb_gnt, ack_s,
    input  gnt, gnt_idx, gnt_valid, preempt
  );

  // Arbiter side.
  modport slave (
    input  req, stb_gnt, ack_s,
    output gnt, gnt_idx, gnt_valid, preempt
  );

endinterface

// File: rtl/wshb_arbiter_rr_pick.sv
// Round-robin priority picker: first set req bit strictly after last_idx,
// searching upward and wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_idx,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan the N candidates in rotated order; the first hit wins.
  always_comb begin
    int               c;
    logic [IDX_W-1:0] ci;
    // NOTE: every output and temporary gets a default before the loop so no
    // path through this block leaves a value held, which would infer a latch.
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    ci    = '0;
    for (int k = 1; k <= N; k++) begin
      // NOTE: blocking assignments here are intentional: each iteration must
      // see the valid/idx values written by the previous iteration.
      c = int'(last_idx) + k;
      if (c >= N) c = c - N;
      ci = IDX_W'(c);
      if (!valid && req[ci]) begin
        valid = 1'b1;
        idx   = ci;
      end
    end
  end

endmodule

// File: rtl/wshb_arbiter.sv
// Wishbone arbiter for a shared SDRAM slave: round-robin grant among
// NB_MASTERS, held per owner until it drops cyc, with ack-count based
// preemption when others are waiting. The bus mux itself lives outside.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int NB_MASTERS = DEF_NB_MASTERS,
  parameter int MAX_ACKS   = DEF_MAX_ACKS
) (
  input logic           clk,
  input logic           rst,
  wshb_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NB_MASTERS);
  localparam int CNT_W = $clog2(MAX_ACKS + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_ACKS);
  localparam logic [CNT_W:0]   QUOTA     = (CNT_W + 1)'(MAX_ACKS);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NB_MASTERS - 1);

  arb_state_e            state;
  logic [IDX_W-1:0]      last_idx;
  logic [CNT_W-1:0]      ack_cnt;
  logic [NB_MASTERS-1:0] gnt_q;
  logic [IDX_W-1:0]      gnt_idx_q;
  logic                  gnt_valid_q;
  logic                  preempt_q;

  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic [NB_MASTERS-1:0] pick_onehot;
  logic                  own_req;
  logic                  others_waiting;
  logic                  quota_hit;
  logic [CNT_W:0]        cnt_plus1;
  logic [CNT_W-1:0]      cnt_next;

  // stb_gnt is carried for observability only: preemption is restricted to
  // ack cycles, which by itself guarantees a pending strobe is never cut.
  logic unused_stb;
  assign unused_stb = bus.stb_gnt;

  rr_pick #(
    .N     (NB_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (bus.req),
    .last_idx (last_idx),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // Ownership bookkeeping: owner still requesting, rivals, ack quota reached.
  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
    own_req               = bus.req[gnt_idx_q];
    others_waiting        = |(bus.req & ~gnt_q);
    // One extra bit so ack_cnt + 1 cannot wrap when the counter is full.
    cnt_plus1             = {1'b0, ack_cnt} + (CNT_W + 1)'(1);
    quota_hit             = (cnt_plus1 >= QUOTA);
    cnt_next              = (ack_cnt == CNT_MAX) ? ack_cnt : cnt_plus1[CNT_W-1:0];
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_idx    <= LAST_INIT;
      ack_cnt     <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // updates from the same pre-edge values, regardless of statement order.
      preempt_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // At least one cycle is always spent here, so gnt is 0 between owners.
          if (pick_valid) begin
            state       <= OWN;
            gnt_q       <= pick_onehot;
            gnt_idx_q   <= pick_idx;
            gnt_valid_q <= 1'b1;
            last_idx    <= pick_idx;
            ack_cnt     <= '0;
          end
        end
        OWN: begin
          if (!own_req) begin
            // Normal release; wins over preemption on a simultaneous ack.
            state       <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
          end else if (bus.ack_s && quota_hit && others_waiting) begin
            // Forced rotation, only at a transfer boundary.
            state       <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b1;
          end else if (bus.ack_s) begin
            ack_cnt     <= cnt_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Self-checking bench for wshb_arbiter: two instances (MAX_ACKS 64 and 4)
// driven with the same stimulus; table vectors feed a scoreboard queue.
module tb_wshb_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wshb_arbiter_if #(.NB_MASTERS(2)) bus_a ();
  wshb_arbiter_if #(.NB_MASTERS(2)) bus_b ();

  wshb_arbiter #(.NB_MASTERS(2), .MAX_ACKS(64)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  wshb_arbiter #(.NB_MASTERS(2), .MAX_ACKS(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    bit         sel;    // 0: dut_a (MAX_ACKS 64), 1: dut_b (MAX_ACKS 4)
    logic [1:0] req;
    logic       stb;
    logic       ack;
    logic [1:0] gnt;    // expected after the next clock edge
    logic       idx;
    logic       pre;
  } vec_t;

  typedef struct {
    bit         sel;
    logic [1:0] gnt;
    logic       idx;
    logic       pre;
    int         id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_id = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(logic [1:0] r, logic s, logic a);
    bus_a.req = r; bus_a.stb_gnt = s; bus_a.ack_s = a;
    bus_b.req = r; bus_b.stb_gnt = s; bus_b.ack_s = a;
  endtask

  function automatic void add(bit sel, logic [1:0] r, logic s, logic a,
                              logic [1:0] g, logic i, logic p);
    vec_t v;
    v.sel = sel; v.req = r; v.stb = s; v.ack = a; v.gnt = g; v.idx = i; v.pre = p;
    tbl.push_back(v);
  endfunction

  task automatic pop_compare();
    exp_t       e;
    logic [1:0] g;
    logic       gv, gi, gp;
    e  = sb_q.pop_front();
    g  = e.sel ? bus_b.gnt       : bus_a.gnt;
    gv = e.sel ? bus_b.gnt_valid : bus_a.gnt_valid;
    gi = e.sel ? bus_b.gnt_idx   : bus_a.gnt_idx;
    gp = e.sel ? bus_b.preempt   : bus_a.preempt;
    check($sformatf("v%0d.gnt", e.id), 32'(g), 32'(e.gnt));
    check($sformatf("v%0d.gnt_valid", e.id), 32'(gv), 32'(|e.gnt));
    check($sformatf("v%0d.preempt", e.id), 32'(gp), 32'(e.pre));
    if (|e.gnt) check($sformatf("v%0d.gnt_idx", e.id), 32'(gi), 32'(e.idx));
  endtask

  // Apply each vector at a falling edge, compare one edge later.
  task automatic run_table();
    exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (sb_q.size() > 0) pop_compare();
      drive(tbl[i].req, tbl[i].stb, tbl[i].ack);
      e.sel = tbl[i].sel; e.gnt = tbl[i].gnt; e.idx = tbl[i].idx;
      e.pre = tbl[i].pre; e.id = vec_id;
      vec_id++;
      sb_q.push_back(e);
    end
    @(negedge clk);
    if (sb_q.size() > 0) pop_compare();
    tbl.delete();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, ".a.gnt"},       32'(bus_a.gnt),       32'd0);
    check({tag, ".a.gnt_idx"},   32'(bus_a.gnt_idx),   32'd0);
    check({tag, ".a.gnt_valid"}, 32'(bus_a.gnt_valid), 32'd0);
    check({tag, ".a.preempt"},   32'(bus_a.preempt),   32'd0);
    check({tag, ".b.gnt"},       32'(bus_b.gnt),       32'd0);
    check({tag, ".b.gnt_valid"}, 32'(bus_b.gnt_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
  endtask

  // Ack of the previous edge, for the preempt-follows-ack invariant.
  logic       ack_q;
  logic [1:0] prev_a, prev_b;

  // Register the ack seen at each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= bus_a.ack_s;
  end

  task automatic inv_check(string tag, logic [1:0] g, logic [1:0] pg, logic v, logic p);
    logic [1:0] gm1;
    gm1 = g - 2'd1;
    check({tag, ".onehot0"},    32'((g & gm1) == 2'b00), 32'd1);
    check({tag, ".valid_or"},   32'(v), 32'(|g));
    check({tag, ".no_switch"},  32'((pg != 2'b00) && (g != 2'b00) && (g != pg)), 32'd0);
    check({tag, ".pre_on_ack"}, 32'(p && !ack_q), 32'd0);
  endtask

  // Per-cycle invariants on both instances.
  always @(negedge clk) begin
    if (rst) begin
      prev_a = 2'b00;
      prev_b = 2'b00;
    end else begin
      inv_check("inv.a", bus_a.gnt, prev_a, bus_a.gnt_valid, bus_a.preempt);
      inv_check("inv.b", bus_b.gnt, prev_b, bus_b.gnt_valid, bus_b.preempt);
      prev_a = bus_a.gnt;
      prev_b = bus_b.gnt;
    end
  end

  initial begin
    rst = 1'b1;
    drive(2'b00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Single master grant/release; ack in IDLE ignored.
    add(0, 2'b00, 0, 0, 2'b00, 0, 0);
    add(0, 2'b01, 0, 0, 2'b01, 0, 0);
    add(0, 2'b01, 1, 0, 2'b01, 0, 0);
    add(0, 2'b00, 0, 0, 2'b00, 0, 0);
    add(0, 2'b00, 0, 1, 2'b00, 0, 0);
    add(0, 2'b01, 0, 0, 2'b01, 0, 0);
    add(0, 2'b01, 1, 1, 2'b01, 0, 0);
    add(0, 2'b00, 0, 0, 2'b00, 0, 0);
    run_table();

    // Both requesting, each owner drops after 4 acks: 01,00,10,00,01.
    do_reset();
    add(0, 2'b11, 0, 0, 2'b01, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 2'b11, 1, 1, 2'b01, 0, 0);
    add(0, 2'b10, 0, 0, 2'b00, 0, 0);
    add(0, 2'b11, 0, 0, 2'b10, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 2'b11, 1, 1, 2'b10, 1, 0);
    add(0, 2'b01, 0, 0, 2'b00, 0, 0);
    add(0, 2'b11, 0, 0, 2'b01, 0, 0);
    add(0, 2'b11, 1, 1, 2'b01, 0, 0);
    run_table();

    // MAX_ACKS=4: preemption on the 4th ack, then master 1.
    do_reset();
    add(1, 2'b11, 0, 0, 2'b01, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 2'b11, 1, 1, 2'b01, 0, 0);
    add(1, 2'b11, 1, 1, 2'b00, 0, 1);
    add(1, 2'b11, 0, 0, 2'b10, 1, 0);
    add(1, 2'b11, 1, 0, 2'b10, 1, 0);
    add(1, 2'b01, 0, 0, 2'b00, 0, 0);
    add(1, 2'b01, 0, 0, 2'b01, 0, 0);
    // Master 0 alone for 10 acks: saturate, hold, then rotate on next ack.
    for (int i = 0; i < 10; i++) add(1, 2'b01, 1, 1, 2'b01, 0, 0);
    add(1, 2'b11, 1, 0, 2'b01, 0, 0);
    add(1, 2'b11, 1, 1, 2'b00, 0, 1);
    add(1, 2'b11, 0, 0, 2'b10, 1, 0);
    // Release on the quota ack counts as normal release: no preempt.
    for (int i = 0; i < 3; i++) add(1, 2'b11, 1, 1, 2'b10, 1, 0);
    add(1, 2'b01, 1, 1, 2'b00, 0, 0);
    add(1, 2'b01, 0, 0, 2'b01, 0, 0);
    add(1, 2'b00, 0, 0, 2'b00, 0, 0);
    run_table();

    // Asynchronous reset mid-ownership with a pending strobe.
    do_reset();
    @(negedge clk);
    drive(2'b10, 1'b1, 1'b0);
    @(negedge clk);
    check("arst.pre.gnt", 32'(bus_a.gnt), 32'h2);
    check("arst.pre.idx", 32'(bus_a.gnt_idx), 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst.gnt",       32'(bus_a.gnt),       32'h0);
    check("arst.gnt_valid", 32'(bus_a.gnt_valid), 32'h0);
    check("arst.gnt_idx",   32'(bus_a.gnt_idx),   32'h0);
    @(negedge clk);
    drive(2'b11, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("rel.gnt_before_edge", 32'(bus_a.gnt), 32'h0);
    @(negedge clk);
    check("rel.first_gnt", 32'(bus_a.gnt), 32'h1);
    check("rel.first_idx", 32'(bus_a.gnt_idx), 32'h0);
    check("rel.first_b",   32'(bus_b.gnt), 32'h1);

    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wshb_arbiter.md
WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 SHALL have parameter NB_MASTERS, default 2, meaning the number of Wishbone masters sharing the SDRAM slave (legal range 2..8).
REQ-002 SHALL have parameter MAX_ACKS, default 64, meaning the number of acknowledged transfers after which the grant may be preempted (legal range 1..1024).
REQ-003 SHALL have port clk, input, 1 bit: the single clock for the block.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, NB_MASTERS bits: the cyc of each master.
REQ-006 SHALL have port stb_gnt, input, 1 bit: the stb of the currently granted master, after the external mux.
REQ-007 SHALL have port ack_s, input, 1 bit: slave ack OR err OR rty, which marks one completed transfer.
REQ-008 SHALL have port gnt, output, NB_MASTERS bits: one-hot grant, which drives the external mux select.
REQ-009 SHALL have port gnt_idx, output, $clog2(NB_MASTERS) bits: binary index of the granted master.
REQ-010 SHALL have port gnt_valid, output, 1 bit: high exactly when gnt is non-zero.
REQ-011 SHALL have port preempt, output, 1 bit: a one-cycle pulse on forced rotation.

Function
REQ-012 The state machine SHALL have two states: IDLE (gnt=0) and OWN (exactly one gnt bit set).
REQ-013 In IDLE with req≠0, the block SHALL select, by round-robin, the first requesting master after last_idx, searching upward modulo NB_MASTERS.
REQ-014 The block SHALL register the IDLE selection and enter OWN, so that gnt appears 1 cycle after req is sampled.
REQ-015 In OWN, gnt, gnt_idx and gnt_valid SHALL stay stable.
REQ-016 On entering OWN, last_idx SHALL be updated to gnt_idx and ack_cnt SHALL be cleared to 0.
REQ-017 In OWN, each cycle with ack_s=1 SHALL increment ack_cnt, which saturates at MAX_ACKS; the width of ack_cnt is $clog2(MAX_ACKS+1).
REQ-018 Normal release: req[gnt_idx]=0 in OWN SHALL move the block to IDLE next cycle, and gnt SHALL drop that cycle.
REQ-019 Preemption: in OWN, when ack_s=1, ack_cnt+1≥MAX_ACKS and any other req bit is set, the block SHALL move to IDLE next cycle and pulse preempt for that one cycle.
REQ-020 Preemption SHALL occur only on an ack cycle, so a transfer is never cut while stb_gnt is pending.
REQ-021 If ack_cnt has saturated and no other requester is waiting, the grant SHALL be held; preemption SHALL then happen at the first ack after another req rises.
REQ-022 Every return to IDLE SHALL leave at least one cycle with gnt=0, so that slave cyc drops between owners.
REQ-023 Release and ack on the same cycle SHALL count as a normal release, with no preempt pulse.
REQ-024 If a master drops req while IDLE is selecting, the selection SHALL use the sampled req of that cycle only; there is no lookahead.
REQ-025 Requests that arrive while OWN SHALL wait; there is no queuing beyond the req level itself.
REQ-026 ack_s received in IDLE SHALL be ignored.

Reset
REQ-027 While rst=1, the outputs SHALL be: gnt=0, gnt_idx=0, gnt_valid=0, preempt=0.
REQ-028 While rst=1, the state SHALL be IDLE, ack_cnt=0 and last_idx=NB_MASTERS-1, so master 0 wins the first arbitration.
REQ-029 Reset asserted mid-ownership SHALL clear gnt immediately, asynchronously, without waiting for an ack.
REQ-030 After rst deasserts, the first grant SHALL appear no earlier than 1 clk edge after req is sampled.

Structure
REQ-031 The state enum (IDLE, OWN) SHALL live in shared package wshb_arb_pkg.
REQ-032 The round-robin priority picker SHALL be a single combinational sub-module, rr_pick (inputs req and last_idx; outputs valid and idx).
REQ-033 The Wishbone signal mux SHALL remain outside this block, driven by gnt.

Verification
REQ-034 Reset release, then req=01 -> gnt=01 one cycle later, gnt_idx=0; req=00 -> gnt=00 next cycle.
REQ-035 Both requesting, NB_MASTERS=2: req=11 held -> grants alternate 01, 00, 10, 00, 01 as each owner drops req in turn after 4 acks.
REQ-036 MAX_ACKS=4, master 0 bursting, master 1 requesting -> preempt pulses on the 4th ack, gnt=00 one cycle, then gnt=10.
REQ-037 MAX_ACKS=4, master 0 alone for 10 acks -> no preempt, gnt=01 throughout; master 1 raises req -> rotation at the next ack.
REQ-038 rst pulsed while gnt=10 with stb_gnt=1 -> gnt=00 in the same cycle; after release with req=11 -> gnt=01 first.
REQ-039 Assertions on every cycle: gnt is one-hot or zero; gnt_valid equals |gnt; gnt never changes from one non-zero value to another without an intervening zero cycle; preempt is only high in a cycle following ack_s=1.
